// File: rtl/pc_sequencer.sv
// Program counter and bounded return-stack sequencer for the MC14500B system.
// Decisions sampled on one rising edge appear on pc at that same edge's output (one-edge latency).
module pc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_reset,
  input  logic              run,
  input  logic              jmp,
  input  logic              rtn,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              seq_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        r_rst_sync;
  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_fetch_valid;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_seq_error;
  logic [ADDR_W-1:0] r_stack [DEPTH];

  logic              w_active;
  logic              w_full;
  logic              w_empty;
  logic              w_step;
  logic              w_push;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_active   = r_rst_sync[1];
  assign w_full     = (r_sp == SP_W'(DEPTH));
  assign w_empty    = (r_sp == '0);
  // a normal sequencing edge: out of restart, running, and already fetching
  assign w_step     = w_active && !pc_reset && run && r_fetch_valid;
  assign w_push     = w_step && jmp && !w_full;
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_pc_inc   = r_pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= '0;
      r_sp          <= '0;
      r_fetch_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_seq_error   <= 1'b0;
    end else if (w_active) begin
      if (pc_reset) begin
        r_pc          <= '0;
        r_sp          <= '0;
        r_fetch_valid <= 1'b0;
        r_overflow    <= 1'b0;
        r_underflow   <= 1'b0;
        r_seq_error   <= 1'b0;
      end else if (run) begin
        // first running edge after restart presents pc=0 without advancing
        if (!r_fetch_valid) begin
          r_fetch_valid <= 1'b1;
        end else if (jmp) begin
          if (w_full) r_overflow <= 1'b1;
          else        r_sp       <= r_sp + SP_W'(1);
          if (rtn) r_seq_error <= 1'b1;
          r_pc <= jmp_addr;
        end else if (rtn) begin
          if (w_empty) begin
            r_underflow <= 1'b1;
            r_pc        <= r_pc + ADDR_W'(2);
          end else begin
            r_sp <= r_sp - SP_W'(1);
            r_pc <= r_stack[w_pop_idx] + ADDR_W'(1);
          end
        end else begin
          r_pc <= w_pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign pc          = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign sp          = r_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign seq_error   = r_seq_error;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: restart, call/return, stack limits, wrap/halt, async reset.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_reset;
  logic       run;
  logic       jmp;
  logic       rtn;
  logic [7:0] jmp_addr;
  logic [7:0] pc;
  logic       fetch_valid;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       overflow;
  logic       underflow;
  logic       seq_error;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc_reset(pc_reset), .run(run), .jmp(jmp), .rtn(rtn),
    .jmp_addr(jmp_addr), .pc(pc), .fetch_valid(fetch_valid), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .overflow(overflow),
    .underflow(underflow), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_reset = 1'b0; run = 1'b0; jmp = 1'b0; rtn = 1'b0; jmp_addr = 8'h00;
    #3;
    total++;
    if ({pc, sp, fetch_valid, overflow, underflow, seq_error, stack_empty, stack_full} !== {8'h00, 3'd0, 1'b0, 3'b000, 2'b10}) begin
      bad++; $display("FAIL reset_state got pc=%h sp=%0d fv=%b ovf=%b unf=%b seq=%b emp=%b full=%b", pc, sp, fetch_valid, overflow, underflow, seq_error, stack_empty, stack_full);
    end
    step();
    reset = 1'b1; pc_reset = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({pc, fetch_valid} !== {8'h00, 1'b0}) begin
        bad++; $display("FAIL restart_hold[%0d] got pc=%h fv=%b want pc=00 fv=0", i, pc, fetch_valid);
      end
    end
    pc_reset = 1'b0;
    step();
    total++;
    if ({pc, fetch_valid} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL restart_first got pc=%h fv=%b want pc=00 fv=1", pc, fetch_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (pc !== 8'(i)) begin
        bad++; $display("FAIL restart_incr got pc=%h want %h", pc, 8'(i));
      end
    end
  endtask

  task automatic test_call_return();
    for (int i = 0; i < 13; i++) step();
    total++;
    if (pc !== 8'h10) begin
      bad++; $display("FAIL reach_10 got pc=%h want 10", pc);
    end
    jmp = 1'b1; jmp_addr = 8'h40;
    step();
    jmp = 1'b0;
    total++;
    if ({pc, sp} !== {8'h40, 3'd1}) begin
      bad++; $display("FAIL call got pc=%h sp=%0d want pc=40 sp=1", pc, sp);
    end
    step(); step(); step();
    rtn = 1'b1;
    step();
    rtn = 1'b0;
    total++;
    if ({pc, sp, overflow, underflow, seq_error} !== {8'h12, 3'd0, 3'b000}) begin
      bad++; $display("FAIL return got pc=%h sp=%0d flags=%b%b%b want pc=12 sp=0 flags=000", pc, sp, overflow, underflow, seq_error);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'h84; exp_pc[1] = 8'h83; exp_pc[2] = 8'h82; exp_pc[3] = 8'h14;
    jmp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jmp_addr = 8'h80 + 8'(i);
      step();
    end
    jmp = 1'b0;
    total++;
    if ({pc, sp, stack_full, overflow, underflow} !== {8'h84, 3'd4, 3'b110}) begin
      bad++; $display("FAIL overflow got pc=%h sp=%0d full=%b ovf=%b unf=%b want pc=84 sp=4 110", pc, sp, stack_full, overflow, underflow);
    end
    rtn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({pc, sp} !== {exp_pc[i], 3'(3 - i)}) begin
        bad++; $display("FAIL unwind[%0d] got pc=%h sp=%0d want pc=%h sp=%0d", i, pc, sp, exp_pc[i], 3 - i);
      end
    end
    step();
    rtn = 1'b0;
    total++;
    if ({pc, sp, stack_empty, underflow, overflow} !== {8'h16, 3'd0, 3'b111}) begin
      bad++; $display("FAIL underflow got pc=%h sp=%0d emp=%b unf=%b ovf=%b want pc=16 sp=0 111", pc, sp, stack_empty, underflow, overflow);
    end
  endtask

  task automatic test_wrap_halt();
    jmp = 1'b1; jmp_addr = 8'hFF;
    step();
    jmp = 1'b0;
    total++;
    if ({pc, sp} !== {8'hFF, 3'd1}) begin
      bad++; $display("FAIL jmp_ff got pc=%h sp=%0d want pc=ff sp=1", pc, sp);
    end
    step();
    total++;
    if (pc !== 8'h00) begin
      bad++; $display("FAIL wrap got pc=%h want 00", pc);
    end
    run = 1'b0; jmp = 1'b1; jmp_addr = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({pc, sp, fetch_valid} !== {8'h00, 3'd1, 1'b1}) begin
        bad++; $display("FAIL halt[%0d] got pc=%h sp=%0d fv=%b want pc=00 sp=1 fv=1", i, pc, sp, fetch_valid);
      end
    end
    run = 1'b1; jmp = 1'b0;
    step();
    total++;
    if ({pc, sp} !== {8'h01, 3'd1}) begin
      bad++; $display("FAIL resume got pc=%h sp=%0d want pc=01 sp=1", pc, sp);
    end
  endtask

  task automatic test_simultaneous();
    jmp = 1'b1; rtn = 1'b1; jmp_addr = 8'h20;
    step();
    jmp = 1'b0; rtn = 1'b0;
    total++;
    if ({pc, sp, seq_error} !== {8'h20, 3'd2, 1'b1}) begin
      bad++; $display("FAIL jmp_rtn got pc=%h sp=%0d seq=%b want pc=20 sp=2 seq=1", pc, sp, seq_error);
    end
    pc_reset = 1'b1;
    step();
    pc_reset = 1'b0;
    total++;
    if ({pc, sp, fetch_valid, overflow, underflow, seq_error} !== {8'h00, 3'd0, 4'b0000}) begin
      bad++; $display("FAIL pc_reset_clear got pc=%h sp=%0d fv=%b flags=%b%b%b want all 0", pc, sp, fetch_valid, overflow, underflow, seq_error);
    end
    step();
    rtn = 1'b1;
    step();
    rtn = 1'b0;
    total++;
    if ({pc, sp, underflow} !== {8'h02, 3'd0, 1'b1}) begin
      bad++; $display("FAIL rtn_after_restart got pc=%h sp=%0d unf=%b want pc=02 sp=0 unf=1", pc, sp, underflow);
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    jmp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jmp_addr = 8'h30 + 8'(i);
      step();
    end
    jmp = 1'b0;
    total++;
    if ({pc, sp} !== {8'h32, 3'd3}) begin
      bad++; $display("FAIL nest3 got pc=%h sp=%0d want pc=32 sp=3", pc, sp);
    end
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({pc, sp, fetch_valid, underflow} !== {8'h00, 3'd0, 2'b00}) begin
      bad++; $display("FAIL async_reset got pc=%h sp=%0d fv=%b unf=%b want pc=00 sp=0 fv=0 unf=0", pc, sp, fetch_valid, underflow);
    end
    step();
    reset = 1'b1;
    step();
    total++;
    if (fetch_valid !== 1'b0) begin
      bad++; $display("FAIL release_sync got fv=%b want 0", fetch_valid);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (fetch_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || pc !== 8'h00) begin
      bad++; $display("FAIL resume_after_reset got seen=%b pc=%h want seen=1 pc=00", seen, pc);
    end
    step();
    total++;
    if (pc !== 8'h01) begin
      bad++; $display("FAIL incr_after_reset got pc=%h want 01", pc);
    end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_overflow();
    test_wrap_halt();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program counter and subroutine-return sequencer for the MC14500B system.
- Receiving end of the staged reset sequence: consumes `pc_reset` from the reset module and the ICU's JMP/RTN flags.
- Produces the program memory address each cycle, with a bounded return stack for nested calls.
- Sits between the reset module and the ICU (upstream) and the program ROM (downstream).

Parameters:
- ADDR_W, 8, width of program address and jump operand.
- DEPTH, 4, number of return-stack entries (1..16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- pc_reset  input  1  synchronous restart request from reset module; may be high for several cycles.
- run  input  1  advance enable; 0 freezes all state (halt via FLAG_F path).
- jmp  input  1  ICU JMP flag, valid one cycle.
- rtn  input  1  ICU RTN flag, valid one cycle.
- jmp_addr  input  ADDR_W  jump target (instruction operand field).
- pc  output  ADDR_W  current program address to ROM.
- fetch_valid  output  1  pc is a legitimate fetch address.
- sp  output  $clog2(DEPTH+1)  current stack occupancy.
- stack_full  output  1  sp == DEPTH.
- stack_empty  output  1  sp == 0.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- seq_error  output  1  sticky: jmp and rtn asserted in the same cycle.

Behaviour:
- Async reset (`reset` = 0):
  - pc=0, sp=0, fetch_valid=0, overflow=underflow=seq_error=0, stack contents don't-care.
  - Reset release is synchronised internally by a 2-flop stage; state is held at reset values until the second rising edge after release.
- Priority per rising edge: `pc_reset` > `!run` > `jmp` > `rtn` > increment.
- `pc_reset` = 1:
  - pc=0, sp=0, all sticky flags cleared, fetch_valid=0. Ignores run/jmp/rtn.
  - fetch_valid rises on the first edge where pc_reset=0 (and run=1). pc=0 is presented for that cycle, not incremented.
- `run` = 0: all registers hold, including fetch_valid. Flags present in the same cycle are dropped (not queued).
- `jmp` (run=1):
  - Push pc+1 (mod 2^ADDR_W) at stack[sp]; sp+=1; pc=jmp_addr.
  - If sp==DEPTH: no push, sp unchanged, overflow<=1, pc still jumps.
- `rtn` (run=1, jmp=0):
  - If sp>0: sp-=1; pc=stack[sp-1]+1 (mod 2^ADDR_W). This skips the instruction after the call, per MC14500B RTN semantics.
  - If sp==0: underflow<=1, pc=pc+2 (skip still honoured).
- `jmp` and `rtn` together: jmp action taken, rtn ignored, seq_error<=1.
- Otherwise: pc=pc+1, wrapping 2^ADDR_W-1 -> 0 with no flag.
- Latency: every decision is visible on pc one edge after the flag is sampled. No combinational path from inputs to pc.
- stack_full/stack_empty decode registered sp combinationally.
- Sticky flags clear only by async reset or pc_reset.
- pc_reset asserted mid-subroutine discards the whole stack; a subsequent rtn underflows.

Test Plan:
- Reset/restart: reset=0 then release, pc_reset high 2 cycles, run=1 -> pc=0 with fetch_valid=0 during pc_reset; fetch_valid=1 with pc=0 on the following cycle, then pc=1,2,3.
- Call/return: pc=0x10, jmp with jmp_addr=0x40 -> pc=0x40, sp=1. Three increments then rtn -> pc=0x12, sp=0, no flags.
- Overflow (DEPTH=4): five nested jmp to 0x80,0x81,0x82,0x83,0x84 -> sp stays 4, overflow=1, pc=0x84. Four rtn unwind correctly; fifth rtn -> underflow=1, pc advances by 2.
- Wrap/halt: pc=0xFF, increment -> pc=0x00. run=0 for 3 cycles with jmp pulsed -> pc, sp unchanged; jmp lost.
- Simultaneous flags: jmp=rtn=1 with jmp_addr=0x20, sp=1 -> pc=0x20, sp=2, seq_error=1. Then pc_reset -> all flags 0, sp=0.
- Async reset mid-call: sp=3, reset=0 asynchronously between edges -> pc=0, sp=0 immediately, without waiting for clk.
